ram_2r1w_be: RTL and testbench

- Parametrised successor to the team's basic memory macro: one write port with byte enables, two independent registered read ports, and a hardware clear engine that zeroes the array after reset or on request.
- Serves as instruction/data memory for the RV32IM core.
- Byte enables implement SB/SH/SW.
- The second read port feeds instruction fetch or a debug reader.

---
 rtl/ram_2r1w_be_if.sv | 32 +++
 rtl/ram_2r1w_be.sv | 148 ++++++++++++++
 tb/tb_ram_2r1w_be.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_2r1w_be_if.sv
// Bus bundle for ram_2r1w_be: clear handshake, byte-enabled write port, two read ports.
interface ram_2r1w_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  clear_req;
  logic                  ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic                  rd_a_en;
  logic [ADDR_WIDTH-1:0] rd_a_addr;
  logic [DATA_WIDTH-1:0] rd_a_data;
  logic                  rd_b_en;
  logic [ADDR_WIDTH-1:0] rd_b_addr;
  logic [DATA_WIDTH-1:0] rd_b_data;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, wr_be,
           rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    input  ready, rd_a_data, rd_b_data
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, wr_be,
           rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    output ready, rd_a_data, rd_b_data
  );
endinterface

// File: rtl/ram_2r1w_be.sv
// 1W/2R byte-lane RAM with zero-fill clear engine; one byte-wide bank per lane.
// Define RAM_WRITE_FORWARD_EN for write-first reads; default is read-first.
module ram_2r1w_be_lane #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic                  re_a,
  input  logic                  ok_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic                  re_b,
  input  logic                  ok_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [7:0]            rdata_a,
  output logic [7:0]            rdata_b
);
  logic [7:0] mem [DEPTH];
  logic [7:0] word_a, word_b;

  // Storage is never reset; the clear engine zeroes it through the write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    word_a = mem[raddr_a];
    word_b = mem[raddr_b];
`ifdef RAM_WRITE_FORWARD_EN
    if (we && waddr == raddr_a) word_a = wdata;
    if (we && waddr == raddr_b) word_b = wdata;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= ok_a ? word_a : 8'h00;
      if (re_b) rdata_b <= ok_b ? word_b : 8'h00;
    end
  end
endmodule

module ram_2r1w_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  ram_2r1w_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > 2 ** ADDR_WIDTH || DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] ptr;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH + 1)'(DEPTH);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      ready_q <= 1'b0;
      ptr     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        READY: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            ptr     <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          ready_q <= 1'b0;
          ptr     <= '0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;

  logic                  clearing, user_we, rd_a_go, rd_b_go, ok_a, ok_b;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [NB-1:0][7:0]    wdata;
  logic [NB-1:0][7:0]    rd_a_lane, rd_b_lane;

  // A write in the clear_req acceptance cycle still lands; the fill then overwrites it.
  assign clearing = (state == CLEAR);
  assign user_we  = ready_q & bus.wr_en & in_range(bus.wr_addr);
  assign rd_a_go  = ready_q & bus.rd_a_en;
  assign rd_b_go  = ready_q & bus.rd_b_en;
  assign ok_a     = in_range(bus.rd_a_addr);
  assign ok_b     = in_range(bus.rd_b_addr);
  assign waddr    = clearing ? ptr : bus.wr_addr;
  assign wdata    = clearing ? '0 : bus.wr_data;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    ram_2r1w_be_lane #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we     (clearing | (user_we & bus.wr_be[i])),
      .waddr  (waddr),
      .wdata  (wdata[i]),
      .re_a   (rd_a_go),
      .ok_a   (ok_a),
      .raddr_a(bus.rd_a_addr),
      .re_b   (rd_b_go),
      .ok_b   (ok_b),
      .raddr_b(bus.rd_b_addr),
      .rdata_a(rd_a_lane[i]),
      .rdata_b(rd_b_lane[i])
    );
  end

  assign bus.rd_a_data = rd_a_lane;
  assign bus.rd_b_data = rd_b_lane;
endmodule

// File: tb/tb_ram_2r1w_be.sv
// Bench for ram_2r1w_be: a 16-deep and a 12-deep instance against a word-array model.
module tb_ram_2r1w_be;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_2r1w_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  ram_2r1w_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  ram_2r1w_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ram_2r1w_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(12)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;

  logic [31:0] m [2][16];
  logic [31:0] ea [2];
  logic [31:0] eb [2];

`ifdef RAM_WRITE_FORWARD_EN
  localparam logic [31:0] RDW_EXP = 32'h1234FFFF;
`else
  localparam logic [31:0] RDW_EXP = 32'h12345678;
`endif

  typedef struct {
    int          op;    // 0 write, 1 read A, 2 read B
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input int d, input logic [3:0] a, input logic we,
                                           input logic [3:0] wa, input logic [31:0] wd,
                                           input logic [3:0] be);
    if (int'(a) >= dep(d)) return 32'h0;
`ifdef RAM_WRITE_FORWARD_EN
    if (we && wa == a) return merge(m[d][a], wd, be);
`endif
    return m[d][a];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic drv(input int d, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic ra, input logic [3:0] aa,
                     input logic rb, input logic [3:0] ab, input logic cr);
    if (d == 0) begin
      b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd; b0.wr_be = be;
      b0.rd_a_en = ra; b0.rd_a_addr = aa; b0.rd_b_en = rb; b0.rd_b_addr = ab; b0.clear_req = cr;
    end else begin
      b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd; b1.wr_be = be;
      b1.rd_a_en = ra; b1.rd_a_addr = aa; b1.rd_b_en = rb; b1.rd_b_addr = ab; b1.clear_req = cr;
    end
  endtask

  task automatic model(input int d, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic ra, input logic [3:0] aa,
                       input logic rb, input logic [3:0] ab);
    if (ra) ea[d] = rd_model(d, aa, we, wa, wd, be);
    if (rb) eb[d] = rd_model(d, ab, we, wa, wd, be);
    if (we && int'(wa) < dep(d)) m[d][wa] = merge(m[d][wa], wd, be);
  endtask

  task automatic op(input int d, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic ra, input logic [3:0] aa,
                    input logic rb, input logic [3:0] ab);
    drv(d, we, wa, wd, be, ra, aa, rb, ab, 1'b0);
    model(d, we, wa, wd, be, ra, aa, rb, ab);
    cyc();
    drv(d, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk_rd(input int d, input string n);
    chk({n, "_a"}, (d == 0) ? b0.rd_a_data : b1.rd_a_data, ea[d]);
    chk({n, "_b"}, (d == 0) ? b0.rd_b_data : b1.rd_b_data, eb[d]);
  endtask

  task automatic zero_model();
    for (int d = 0; d < 2; d++) for (int a = 0; a < 16; a++) m[d][a] = 32'h0;
  endtask

  // Counts sampled cycles until each instance reports ready, within a fixed budget.
  task automatic count_ready(input string n, input int exp0, input int exp1);
    int n0, n1;
    n0 = -1; n1 = -1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (n0 < 0 && b0.ready) n0 = c;
      if (n1 < 0 && b1.ready) n1 = c;
      if (n0 >= 0 && n1 >= 0) break;
    end
    chk({n, "_cyc16"}, 32'(n0), 32'(exp0));
    chk({n, "_cyc12"}, 32'(n1), 32'(exp1));
  endtask

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{0, 4'd3,  32'hAABBCCDD, 4'b1111, 32'h0},
      '{0, 4'd3,  32'h11223344, 4'b0101, 32'h0},
      '{1, 4'd3,  32'h0,        4'b0000, 32'hAA22CC44},
      '{2, 4'd3,  32'h0,        4'b0000, 32'hAA22CC44},
      '{0, 4'd1,  32'h00000001, 4'b1111, 32'h0},
      '{0, 4'd2,  32'h00000002, 4'b1111, 32'h0},
      '{1, 4'd1,  32'h0,        4'b0000, 32'h00000001},
      '{2, 4'd2,  32'h0,        4'b0000, 32'h00000002},
      '{0, 4'd15, 32'hDEADBEEF, 4'b1000, 32'h0},
      '{1, 4'd15, 32'h0,        4'b0000, 32'hDE000000},
      '{0, 4'd15, 32'h12345678, 4'b0000, 32'h0},
      '{2, 4'd15, 32'h0,        4'b0000, 32'hDE000000},
      '{0, 4'd0,  32'hCAFEF00D, 4'b0110, 32'h0},
      '{1, 4'd0,  32'h0,        4'b0000, 32'h00FEF000}
    };
    for (int d = 0; d < 2; d++) drv(d, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset state and power-on clear length
    repeat (3) cyc();
    chk("rst_ready0", {31'b0, b0.ready}, 32'h0);
    chk("rst_ready1", {31'b0, b1.ready}, 32'h0);
    chk("rst_rda0", b0.rd_a_data, 32'h0);
    chk("rst_rdb0", b0.rd_b_data, 32'h0);
    rst = 1'b0;
    count_ready("boot", 16, 12);
    zero_model();
    ea = '{32'h0, 32'h0};
    eb = '{32'h0, 32'h0};
    for (int a = 0; a < 16; a++) begin
      op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a), 1'b1, 4'(15 - a));
      chk_rd(0, "boot_zero");
    end

    // Table vectors on the 16-deep instance
    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        0: op(0, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].be, 1'b0, 4'd0, 1'b0, 4'd0);
        1: begin
          op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, vecs[i].addr, 1'b0, 4'd0);
          chk("vec_a", b0.rd_a_data, vecs[i].exp);
        end
        default: begin
          op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, vecs[i].addr);
          chk("vec_b", b0.rd_b_data, vecs[i].exp);
        end
      endcase
    end

    // Dual read then hold with enables low and addresses moved
    op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd1, 1'b1, 4'd2);
    chk("dual_a", b0.rd_a_data, 32'h1);
    chk("dual_b", b0.rd_b_data, 32'h2);
    drv(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd7, 1'b0, 4'd9, 1'b0);
    cyc(); cyc();
    chk("hold_a", b0.rd_a_data, 32'h1);
    chk("hold_b", b0.rd_b_data, 32'h2);

    // Read-during-write on both ports
    op(0, 1'b1, 4'd5, 32'h12345678, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);
    op(0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd5, 1'b1, 4'd5);
    chk("rdw_a", b0.rd_a_data, RDW_EXP);
    chk("rdw_b", b0.rd_b_data, RDW_EXP);
    op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0);
    chk("rdw_next", b0.rd_a_data, 32'h1234FFFF);

    // clear_req with a concurrent write; writes and reads during the fill are ignored
    drv(0, 1'b1, 4'd4, 32'h55555555, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    cyc();
    chk("clr_ack", {31'b0, b0.ready}, 32'h0);
    drv(0, 1'b1, 4'd0, 32'hA5A5A5A5, 4'b1111, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
    count_ready("clr", 16, 1);
    drv(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    chk("clr_hold_a", b0.rd_a_data, ea[0]);
    chk("clr_hold_b", b0.rd_b_data, eb[0]);
    for (int a = 0; a < 16; a++) m[0][a] = 32'h0;
    op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd4);
    chk_rd(0, "clr_zero");

    // Abort a clear with rst at its 7th cycle
    op(0, 1'b1, 4'd8, 32'h88888888, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);
    op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd8, 1'b1, 4'd8);
    chk("pre_abort", b0.rd_a_data, 32'h88888888);
    drv(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    cyc();
    chk("abort_ack", {31'b0, b0.ready}, 32'h0);
    drv(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    chk("abort_ready", {31'b0, b0.ready}, 32'h0);
    chk("abort_rda", b0.rd_a_data, 32'h0);
    chk("abort_rdb", b0.rd_b_data, 32'h0);
    rst = 1'b0;
    count_ready("abort", 16, 12);
    zero_model();
    ea = '{32'h0, 32'h0};
    eb = '{32'h0, 32'h0};
    for (int a = 0; a < 16; a++) begin
      op(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a), 1'b1, 4'(15 - a));
      chk_rd(0, "abort_zero");
    end

    // Out-of-range addresses on the 12-deep instance
    op(1, 1'b1, 4'd13, 32'hBADC0FFE, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);
    op(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd13, 1'b0, 4'd0);
    chk("oor_rd13", b1.rd_a_data, 32'h0);
    op(1, 1'b1, 4'd11, 32'h0B0B0B0B, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);
    op(1, 1'b1, 4'd12, 32'h12121212, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);
    op(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd11, 1'b1, 4'd12);
    chk("oor_last", b1.rd_a_data, 32'h0B0B0B0B);
    chk("oor_rd12", b1.rd_b_data, 32'h0);
    for (int a = 0; a < 12; a++) begin
      op(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a), 1'b0, 4'd0);
      chk_rd(1, "oor_scan");
    end

    // Random traffic on both instances, with frequent same-address collisions
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        logic        we, ra, rb;
        logic [3:0]  wa, aa, ab, be;
        logic [31:0] wd;
        we = 1'($urandom_range(0, 1));
        wa = 4'($urandom_range(0, 15));
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
        aa = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
        ab = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
        drv(d, we, wa, wd, be, ra, aa, rb, ab, 1'b0);
        model(d, we, wa, wd, be, ra, aa, rb, ab);
      end
      cyc();
      chk_rd(0, "rnd0");
      chk_rd(1, "rnd1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
